dma_wr_packer: RTL

Write-back path of the AFU: after the CPU halts, reads result words from the local memory through the memory controller's DMA port, assembles them into 512-bit cache lines, and pushes them into the DMA write FIFO (`dma.wr_data` / `dma.wr_en`). It is the transmit-side counterpart of `dma_fsm`, which unpacks host cache lines into memory words. It sits between `memory_controller` (DMA port) and the `dma_if` write channel.

---
 rtl/dma_wr_packer_pkg.sv | 19 +
 rtl/dma_wr_packer_if.sv | 26 ++
 rtl/dma_wr_packer.sv | 115 +++++++++++
 3 files changed

// File: rtl/dma_wr_packer_pkg.sv
// Shared definitions for the DMA write-back packer: cache-line geometry,
// line-count type and the packer state encoding.
package dma_wr_packer_pkg;

  localparam int unsigned CL_WIDTH     = 512;
  localparam int unsigned WORD_SIZE    = 32;
  localparam int unsigned WORDS_PER_CL = CL_WIDTH / WORD_SIZE;
  localparam int unsigned SIZE_WIDTH   = 43;

  typedef logic [SIZE_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_PUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dma_wr_packer_if.sv
// Memory-controller DMA read port plus DMA write-FIFO channel seen by the packer.
interface dma_wr_packer_if #(
  parameter int unsigned CL_WIDTH  = dma_wr_packer_pkg::CL_WIDTH,
  parameter int unsigned WORD_SIZE = dma_wr_packer_pkg::WORD_SIZE
);

  logic                 MemEn;
  logic                 MemWrEn;
  logic [31:0]          MemAddr;
  logic [WORD_SIZE-1:0] MemOut;
  logic                 MemValid;
  logic [CL_WIDTH-1:0]  wr_data;
  logic                 wr_en;
  logic                 full;

  modport master (
    output MemEn, MemWrEn, MemAddr, wr_data, wr_en,
    input  MemOut, MemValid, full
  );

  modport slave (
    input  MemEn, MemWrEn, MemAddr, wr_data, wr_en,
    output MemOut, MemValid, full
  );

endinterface

// File: rtl/dma_wr_packer.sv
// Reads result words from local memory, packs them into cache lines (word 0 in
// the LSBs) and pushes each completed line into the DMA write FIFO.
module dma_wr_packer #(
  parameter int unsigned CL_WIDTH   = dma_wr_packer_pkg::CL_WIDTH,
  parameter int unsigned WORD_SIZE  = dma_wr_packer_pkg::WORD_SIZE,
  parameter int unsigned SIZE_WIDTH = dma_wr_packer_pkg::SIZE_WIDTH,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  dma_wr_packer_if.master       bus
);
  import dma_wr_packer_pkg::*;

  localparam int unsigned WORDS = CL_WIDTH / WORD_SIZE;
  localparam int unsigned WIDX  = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                state_q, state_d;
  logic [WIDX-1:0]       word_q, word_d;
  logic [SIZE_WIDTH-1:0] line_q, line_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [WORD_SIZE-1:0]  buf_q [WORDS];

  logic mem_en;
  logic push;
  logic word_xfer;

  assign word_xfer = (state_q == ST_REQ) && bus.MemValid;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    line_d  = line_q;
    size_d  = size_q;
    mem_en  = 1'b0;
    push    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          size_d  = size;
          word_d  = '0;
          line_d  = '0;
          state_d = (size == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_en = 1'b1;
        if (bus.MemValid) begin
          if (word_q == WIDX'(WORDS - 1)) begin
            word_d  = '0;
            state_d = ST_PUSH;
          end else begin
            word_d = word_q + WIDX'(1);
          end
        end
      end
      ST_PUSH: begin
        push = !bus.full;
        if (push) begin
          line_d  = line_q + SIZE_WIDTH'(1);
          state_d = (line_q + SIZE_WIDTH'(1) == size_q) ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      line_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      line_q  <= line_d;
      size_q  <= size_d;
    end
  end

  // Line buffer is not cleared between lines: every slot is rewritten before the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (word_xfer) begin
      buf_q[word_q] <= bus.MemOut;
    end
  end

  always_comb begin
    bus.wr_data = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      bus.wr_data[i*WORD_SIZE +: WORD_SIZE] = buf_q[i];
    end
  end

  assign bus.MemAddr = BASE_ADDR + 32'(line_q) * 32'(WORDS) + 32'(word_q);
  assign bus.MemEn   = mem_en;
  assign bus.MemWrEn = 1'b0;
  assign bus.wr_en   = push;
  assign busy        = (state_q != ST_IDLE);

endmodule
